// File: rtl/msk_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : msk_tx_frame_ctrl
//  Purpose  : Frame sequencer for the MSK modulator. Emits PREAMBLE_LEN
//             preamble bytes followed by frame_len payload bytes drawn from
//             an upstream valid/ready byte stream. Each byte gets a one-cycle
//             modulator reset (LOAD), then SAMPLES_PER_BYTE cycles of enable.
//  Ports    : G_CLK_TX   - TX clock (only clock)
//             reset      - synchronous active-high reset
//             start      - frame request, sampled in IDLE only
//             frame_len  - payload byte count, latched with start
//             abort      - kill current frame (highest priority)
//             s_data/s_valid/s_ready - upstream byte stream
//             mod_rst_n/mod_enable/mod_data - modulator controls
//             busy/done/underrun/byte_cnt   - status
//  Revision : 1.0 - initial release
// ============================================================================
module msk_tx_frame_ctrl #(
  parameter int         SAMPLES_PER_BYTE = 256,
  parameter int         PREAMBLE_LEN     = 4,
  parameter logic [7:0] PREAMBLE_BYTE    = 8'h55
) (
  input  logic       G_CLK_TX,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       mod_rst_n,
  output logic       mod_enable,
  output logic [7:0] mod_data,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [7:0] byte_cnt
);

  localparam int              SW        = $clog2(SAMPLES_PER_BYTE);
  localparam logic [SW-1:0]   SAMP_LAST = SW'(SAMPLES_PER_BYTE - 1);
  localparam logic [3:0]      PRE_INIT  = 4'(PREAMBLE_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] samp_cnt, samp_nxt;
  logic [3:0]    pre_cnt, pre_nxt, pre_after;
  logic [7:0]    len_q, len_nxt;
  logic [7:0]    acc_cnt, acc_nxt;
  logic [7:0]    hold_data, hold_data_nxt;
  logic          hold_full, hold_full_nxt;
  logic [7:0]    byte_cnt_nxt;
  logic [7:0]    mod_data_nxt;
  logic          underrun_nxt;
  logic          s_ready_nxt;
  logic          handshake, hold_avail;
  logic          load_preamble, load_payload;

  // A byte arriving this cycle counts as available, so a late upstream
  // byte still goes straight into LOAD without an extra WAIT cycle.
  assign handshake  = s_valid & s_ready;
  assign hold_avail = hold_full | handshake;

  always_comb begin
    state_nxt     = state;
    samp_nxt      = samp_cnt;
    pre_nxt       = pre_cnt;
    pre_after     = pre_cnt;
    len_nxt       = len_q;
    acc_nxt       = acc_cnt;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    byte_cnt_nxt  = byte_cnt;
    mod_data_nxt  = mod_data;
    underrun_nxt  = 1'b0;
    load_preamble = 1'b0;
    load_payload  = 1'b0;

    if (handshake) begin
      acc_nxt       = acc_cnt + 8'd1;
      hold_data_nxt = s_data;
      hold_full_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          len_nxt      = frame_len;
          pre_nxt      = PRE_INIT;
          acc_nxt      = 8'd0;
          byte_cnt_nxt = 8'd0;
          if (PRE_INIT != 4'd0)       load_preamble = 1'b1;
          else if (hold_full)         load_payload  = 1'b1;
          else if (frame_len == 8'd0) state_nxt     = S_DONE; // nothing to send at all
          else                        state_nxt     = S_WAIT; // initial wait: no underrun
        end
      end
      S_LOAD: begin
        state_nxt = S_RUN;
        samp_nxt  = '0;
      end
      S_RUN: begin
        samp_nxt = samp_cnt + 1'b1;
        if (samp_cnt == SAMP_LAST) begin
          // A nonzero preamble counter during RUN means a preamble byte is on air.
          if (pre_cnt != 4'd0) pre_after    = pre_cnt - 4'd1;
          else                 byte_cnt_nxt = byte_cnt + 8'd1;
          pre_nxt = pre_after;
          if (pre_after != 4'd0)           load_preamble = 1'b1;
          else if (byte_cnt_nxt == len_q)  state_nxt     = S_DONE;
          else if (hold_avail)             load_payload  = 1'b1;
          else begin
            state_nxt    = S_WAIT;
            underrun_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (hold_avail) load_payload = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (load_preamble) begin
      state_nxt    = S_LOAD;
      mod_data_nxt = PREAMBLE_BYTE;
    end
    if (load_payload) begin
      state_nxt     = S_LOAD;
      mod_data_nxt  = hold_full ? hold_data : s_data;
      hold_full_nxt = 1'b0;
    end

    // Abort overrides everything; byte_cnt keeps the pre-abort value.
    if (abort && state != S_IDLE) begin
      state_nxt     = S_IDLE;
      hold_full_nxt = 1'b0;
      underrun_nxt  = 1'b0;
      byte_cnt_nxt  = byte_cnt;
      mod_data_nxt  = mod_data;
    end

    s_ready_nxt = !hold_full_nxt && (state_nxt != S_IDLE) && (acc_nxt < len_nxt);
  end

  // Outputs are registered from next-state values so each one lines up with
  // the state it accompanies.
  always_ff @(posedge G_CLK_TX) begin
    if (reset) begin
      state      <= S_IDLE;
      samp_cnt   <= '0;
      pre_cnt    <= 4'd0;
      len_q      <= 8'd0;
      acc_cnt    <= 8'd0;
      hold_data  <= 8'd0;
      hold_full  <= 1'b0;
      byte_cnt   <= 8'd0;
      mod_data   <= 8'd0;
      mod_rst_n  <= 1'b0;
      mod_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      state      <= state_nxt;
      samp_cnt   <= samp_nxt;
      pre_cnt    <= pre_nxt;
      len_q      <= len_nxt;
      acc_cnt    <= acc_nxt;
      hold_data  <= hold_data_nxt;
      hold_full  <= hold_full_nxt;
      byte_cnt   <= byte_cnt_nxt;
      mod_data   <= mod_data_nxt;
      mod_rst_n  <= (state_nxt == S_RUN);
      mod_enable <= (state_nxt == S_RUN);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      underrun   <= underrun_nxt;
      s_ready    <= s_ready_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msk_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msk_tx_frame_ctrl
//  Purpose  : Directed self-checking bench for msk_tx_frame_ctrl with
//             default parameters (256 samples/byte, 4 preamble bytes of 55h).
//             Cycle 0 is the cycle in which start is driven.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msk_tx_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] frame_len;
  logic       abort;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       mod_rst_n;
  logic       mod_enable;
  logic [7:0] mod_data;
  logic       busy;
  logic       done;
  logic       underrun;
  logic [7:0] byte_cnt;

  int cyc, n_asserts, n_fail;
  int urun_seen, done_seen, hs_seen, sr_seen, done_cyc;

  msk_tx_frame_ctrl dut (
    .G_CLK_TX  (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mod_rst_n (mod_rst_n),
    .mod_enable(mod_enable),
    .mod_data  (mod_data),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge. Incoming bytes
  // follow a C0, C1, ... sequence on every handshake.
  task automatic step();
    logic hs;
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      hs_seen++;
      s_data = s_data + 8'd1;
    end
    if (underrun) urun_seen++;
    if (done)     done_seen++;
    if (s_ready)  sr_seen++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic begin_frame(input logic [7:0] len);
    frame_len = len;
    start     = 1'b1;
    cyc       = 0;
    urun_seen = 0;
    done_seen = 0;
    hs_seen   = 0;
    sr_seen   = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n        = 0;
    done_cyc = -1;
    while (n < budget && done_cyc < 0) begin
      step();
      n++;
      if (done) done_cyc = cyc;
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    frame_len = 8'd0;
    abort     = 1'b0;
    s_data    = 8'h00;
    s_valid   = 1'b0;
    repeat (3) step();
    chk("rst_ctl", {busy, mod_rst_n, mod_enable, s_ready, done, underrun}, 6'b000000);
    chk("rst_data", mod_data, 8'h00);
    chk("rst_cnt", byte_cnt, 8'h00);
    reset = 1'b0;
    step();

    // Scenario 1: 2-byte payload, upstream always ready
    s_valid = 1'b1;
    s_data  = 8'hC0;
    begin_frame(8'd2);
    chk("s1_load_data", mod_data, 8'h55);
    chk("s1_load_ctl", {mod_rst_n, mod_enable, busy}, 3'b001);
    step();
    chk("s1_run_ctl", {mod_rst_n, mod_enable}, 2'b11);
    step_to(257);
    chk("s1_run_end", mod_enable, 1'b1);
    step();
    chk("s1_load2", {mod_rst_n, mod_enable, mod_data}, {2'b00, 8'h55});
    step_to(1029);
    chk("s1_pay0", mod_data, 8'hC0);
    chk("s1_cnt0", byte_cnt, 8'd0);
    step_to(1286);
    chk("s1_pay1", mod_data, 8'hC1);
    chk("s1_cnt1", byte_cnt, 8'd1);
    wait_done(400);
    chk("s1_done_cyc", done_cyc, 1543);
    chk("s1_cnt2", byte_cnt, 8'd2);
    chk("s1_urun", urun_seen, 0);
    chk("s1_hs", hs_seen, 2);
    step();
    chk("s1_idle", {busy, done}, 2'b00);

    // Scenario 5: start during RUN is ignored
    s_data = 8'hC0;
    begin_frame(8'd2);
    step_to(500);
    start     = 1'b1;
    frame_len = 8'd9;
    step();
    start = 1'b0;
    wait_done(1200);
    chk("s5_done_cyc", done_cyc, 1543);
    chk("s5_cnt", byte_cnt, 8'd2);
    chk("s5_hs", hs_seen, 2);
    step();

    // Scenario 2: preamble-only frame
    begin_frame(8'd0);
    wait_done(1100);
    chk("s2_done_cyc", done_cyc, 1029);
    chk("s2_sready", sr_seen, 0);
    chk("s2_cnt", byte_cnt, 8'd0);
    chk("s2_urun", urun_seen, 0);
    step();

    // Scenario 3: upstream starves after preamble
    s_valid = 1'b0;
    begin_frame(8'd3);
    step_to(1028);
    chk("s3_last_pre", mod_enable, 1'b1);
    step();
    chk("s3_urun", underrun, 1'b1);
    chk("s3_wait_ctl", {mod_rst_n, mod_enable, busy, s_ready}, 4'b0011);
    step_to(1050);
    chk("s3_urun_once", urun_seen, 1);
    s_valid = 1'b1;
    s_data  = 8'hA7;
    step();
    s_valid = 1'b0;
    chk("s3_load_data", mod_data, 8'hA7);
    chk("s3_load_ctl", {mod_rst_n, mod_enable, busy}, 3'b001);
    step_to(1307);
    chk("s3_run", mod_enable, 1'b1);
    step();
    chk("s3_urun2", {underrun, mod_enable}, 2'b10);
    chk("s3_cnt", byte_cnt, 8'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s3_abort", busy, 1'b0);

    // Scenario 4: abort mid-payload
    s_valid = 1'b1;
    s_data  = 8'hC0;
    begin_frame(8'd2);
    step_to(1130);
    chk("s4_pre_abort", {mod_enable, mod_data}, {1'b1, 8'hC0});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_abort_ctl", {busy, mod_rst_n, mod_enable, done}, 4'b0000);
    chk("s4_cnt", byte_cnt, 8'd0);
    repeat (20) step();
    chk("s4_no_done", done_seen, 0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("s4_start_abort", busy, 1'b0);
    begin_frame(8'd2);
    chk("s4_restart", {busy, mod_data}, {1'b1, 8'h55});
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Scenario 6: reset mid-RUN
    begin_frame(8'd2);
    step_to(50);
    reset = 1'b1;
    step();
    chk("s6_rst_ctl", {busy, mod_rst_n, mod_enable, s_ready, done, underrun}, 6'b000000);
    chk("s6_rst_data", {mod_data, byte_cnt}, 16'h0000);
    reset = 1'b0;
    step();
    chk("s6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
